// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - encodings, decoded-slot/pair structs, head FSM states and RAW rule
package decode_pkg;

   localparam logic [6:0]  OP_R     = 7'b0110011;
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [2:0]  F3_ADD   = 3'b000;
   localparam logic [2:0]  F3_WORD  = 3'b010;
   localparam logic [6:0]  F7_ADD   = 7'b0000000;
   localparam logic [6:0]  F7_MUL   = 7'b0000001;
   localparam logic [31:0] NOP_ENC  = 32'h00000013;

   // Bit positions inside the one-hot type vector
   localparam int T_ADD   = 0;
   localparam int T_MUL   = 1;
   localparam int T_LOAD  = 2;
   localparam int T_STORE = 3;
   localparam int T_NOP   = 4;

   typedef struct packed {
      logic [4:0]  typ;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        illegal;
   } slot_dec_t;

   typedef struct packed {
      slot_dec_t s1;
      slot_dec_t s2;
      logic      hz;
   } pair_ent_t;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      HOLD     = 2'd1,
      RELEASED = 2'd2
   } head_state_e;

   // Slot 2 reads a register that slot 1 of the same pair writes
   function automatic logic raw_hazard(input slot_dec_t s1, input slot_dec_t s2);
      logic writes;
      logic uses_rs2;
      writes   = s1.typ[T_ADD] | s1.typ[T_MUL] | s1.typ[T_LOAD];
      uses_rs2 = s2.typ[T_ADD] | s2.typ[T_MUL] | s2.typ[T_STORE];
      return writes && (s1.rd != 5'd0) &&
             ((s1.rd == s2.rs1) || (uses_rs2 && (s1.rd == s2.rs2)));
   endfunction

endpackage

// File: rtl/instr_slot_decoder.sv
// rtl/instr_slot_decoder.sv - combinational RV32 subset decoder for one issue slot
module instr_slot_decoder
   import decode_pkg::*;
(
   input  logic [31:0] instr_i,
   output slot_dec_t   dec_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   // Classify the encoding; unsupported encodings become an illegal nop with zeroed fields
   always_comb begin
      dec_o = '0;
      if (instr_i == NOP_ENC) begin
         dec_o.typ[T_NOP] = 1'b1;
         dec_o.rs1        = instr_i[19:15];
         dec_o.rs2        = instr_i[24:20];
         dec_o.rd         = instr_i[11:7];
      end else if (opcode == OP_R && funct3 == F3_ADD && funct7 == F7_ADD) begin
         dec_o.typ[T_ADD] = 1'b1;
         dec_o.rs1        = instr_i[19:15];
         dec_o.rs2        = instr_i[24:20];
         dec_o.rd         = instr_i[11:7];
      end else if (opcode == OP_R && funct3 == F3_ADD && funct7 == F7_MUL) begin
         dec_o.typ[T_MUL] = 1'b1;
         dec_o.rs1        = instr_i[19:15];
         dec_o.rs2        = instr_i[24:20];
         dec_o.rd         = instr_i[11:7];
      end else if (opcode == OP_LOAD && funct3 == F3_WORD) begin
         dec_o.typ[T_LOAD] = 1'b1;
         dec_o.rs1         = instr_i[19:15];
         dec_o.rd          = instr_i[11:7];
         dec_o.imm         = {{20{instr_i[31]}}, instr_i[31:20]};
      end else if (opcode == OP_STORE && funct3 == F3_WORD) begin
         dec_o.typ[T_STORE] = 1'b1;
         dec_o.rs1          = instr_i[19:15];
         dec_o.rs2          = instr_i[24:20];
         dec_o.imm          = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end else begin
         dec_o.typ[T_NOP] = 1'b1;
         dec_o.illegal    = 1'b1;
      end
   end

endmodule

// File: rtl/dual_issue_decode_queue.sv
// rtl/dual_issue_decode_queue.sv - decode-at-push pair FIFO with head hold/release FSM
module dual_issue_decode_queue
   import decode_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   input  logic [31:0]      instr1,
   input  logic [31:0]      instr2,
   output logic             instr_ready,
   input  logic             slot1_retire,
   input  logic             pair_retire,
   output logic             pair_valid,
   output logic             type_add1,
   output logic             type_mul1,
   output logic             type_load1,
   output logic             type_store1,
   output logic             type_nop1,
   output logic             type_add2,
   output logic             type_mul2,
   output logic             type_load2,
   output logic             type_store2,
   output logic             type_nop2,
   output logic [4:0]       rs1_1,
   output logic [4:0]       rs2_1,
   output logic [4:0]       rd_1,
   output logic [4:0]       rs1_2,
   output logic [4:0]       rs2_2,
   output logic [4:0]       rd_2,
   output logic [31:0]      immediate1,
   output logic [31:0]      immediate2,
   output logic             data_hazard,
   output logic             illegal1,
   output logic             illegal2,
   output logic [PTR_W:0]   occupancy
);

   slot_dec_t   dec1;
   slot_dec_t   dec2;
   pair_ent_t   new_ent;
   pair_ent_t   head;
   pair_ent_t   mem_q [DEPTH];

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0] occ_q, occ_d;
   head_state_e    state_q, state_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   instr_slot_decoder u_dec1 (.instr_i(instr1), .dec_o(dec1));
   instr_slot_decoder u_dec2 (.instr_i(instr2), .dec_o(dec2));

   assign new_ent = '{s1: dec1, s2: dec2, hz: raw_hazard(dec1, dec2)};

   // Wrap bit differs and index bits match exactly when all entries are used
   assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = instr_valid && !full;
   assign pop   = pair_retire && !empty;
   assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Pointer, occupancy and FSM next-state
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      occ_d    = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (pop && !push) begin
         occ_d = occ_q - 1'b1;
      end

      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (occ_d != '0) state_d = HOLD;
         end
         HOLD: begin
            if (pop)               state_d = (occ_d != '0) ? HOLD : EMPTY;
            else if (slot1_retire) state_d = RELEASED;
         end
         RELEASED: begin
            if (pop) state_d = (occ_d != '0) ? HOLD : EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Control state registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         state_q  <= EMPTY;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         state_q  <= state_d;
      end
   end

   // Decoded pair storage; contents are only observed while the FSM is non-empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= new_ent;
      end
   end

   assign instr_ready = !full;
   assign occupancy   = occ_q;

   // Head presentation, forced to zero while nothing is queued
   always_comb begin
      pair_valid  = (state_q != EMPTY);
      data_hazard = (state_q == HOLD) && head.hz;
      {type_nop1, type_store1, type_load1, type_mul1, type_add1} = 5'b0;
      {type_nop2, type_store2, type_load2, type_mul2, type_add2} = 5'b0;
      rs1_1      = '0;
      rs2_1      = '0;
      rd_1       = '0;
      rs1_2      = '0;
      rs2_2      = '0;
      rd_2       = '0;
      immediate1 = '0;
      immediate2 = '0;
      illegal1   = 1'b0;
      illegal2   = 1'b0;
      if (pair_valid) begin
         type_add1   = head.s1.typ[T_ADD];
         type_mul1   = head.s1.typ[T_MUL];
         type_load1  = head.s1.typ[T_LOAD];
         type_store1 = head.s1.typ[T_STORE];
         type_nop1   = head.s1.typ[T_NOP];
         type_add2   = head.s2.typ[T_ADD];
         type_mul2   = head.s2.typ[T_MUL];
         type_load2  = head.s2.typ[T_LOAD];
         type_store2 = head.s2.typ[T_STORE];
         type_nop2   = head.s2.typ[T_NOP];
         rs1_1       = head.s1.rs1;
         rs2_1       = head.s1.rs2;
         rd_1        = head.s1.rd;
         rs1_2       = head.s2.rs1;
         rs2_2       = head.s2.rs2;
         rd_2        = head.s2.rd;
         immediate1  = head.s1.imm;
         immediate2  = head.s2.imm;
         illegal1    = head.s1.illegal;
         illegal2    = head.s2.illegal;
      end
   end

endmodule

// File: tb/tb_dual_issue_decode_queue.sv
// tb/tb_dual_issue_decode_queue.sv - randomized reference-model bench for dual_issue_decode_queue
module tb_dual_issue_decode_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr1 = '0;
   logic [31:0] instr2 = '0;
   logic        instr_ready;
   logic        slot1_retire = 1'b0;
   logic        pair_retire = 1'b0;
   logic        pair_valid;
   logic        type_add1, type_mul1, type_load1, type_store1, type_nop1;
   logic        type_add2, type_mul2, type_load2, type_store2, type_nop2;
   logic [4:0]  rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
   logic [31:0] immediate1, immediate2;
   logic        data_hazard;
   logic        illegal1, illegal2;
   logic [2:0]  occupancy;

   dual_issue_decode_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr1(instr1), .instr2(instr2), .instr_ready(instr_ready),
      .slot1_retire(slot1_retire), .pair_retire(pair_retire), .pair_valid(pair_valid),
      .type_add1(type_add1), .type_mul1(type_mul1), .type_load1(type_load1),
      .type_store1(type_store1), .type_nop1(type_nop1),
      .type_add2(type_add2), .type_mul2(type_mul2), .type_load2(type_load2),
      .type_store2(type_store2), .type_nop2(type_nop2),
      .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
      .immediate1(immediate1), .immediate2(immediate2), .data_hazard(data_hazard),
      .illegal1(illegal1), .illegal2(illegal2), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // ty bits: 0 add, 1 mul, 2 load, 3 store, 4 nop
   typedef struct packed {
      logic [4:0]  ty;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        ill;
   } mslot_t;

   typedef struct packed {
      mslot_t a;
      mslot_t b;
      logic   hz;
   } mpair_t;

   mpair_t q[$];
   bit     released = 1'b0;
   int     checks = 0;
   int     failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mslot_t ref_decode(input logic [31:0] w);
      mslot_t d;
      d = '0;
      if (w == 32'h00000013) begin
         d.ty = 5'b10000;
      end else if ((w & 32'hFE00707F) == 32'h00000033) begin
         d.ty = 5'b00001; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
      end else if ((w & 32'hFE00707F) == 32'h02000033) begin
         d.ty = 5'b00010; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
      end else if ((w & 32'h0000707F) == 32'h00002003) begin
         d.ty = 5'b00100; d.rs1 = w[19:15]; d.rd = w[11:7];
         d.imm = 32'($signed(w[31:20]));
      end else if ((w & 32'h0000707F) == 32'h00002023) begin
         d.ty = 5'b01000; d.rs1 = w[19:15]; d.rs2 = w[24:20];
         d.imm = 32'($signed({w[31:25], w[11:7]}));
      end else begin
         d.ty = 5'b10000; d.ill = 1'b1;
      end
      return d;
   endfunction

   function automatic bit ref_hz(input mslot_t s1, input mslot_t s2);
      bit writes;
      bit reads2;
      writes = (s1.ty == 5'b00001) || (s1.ty == 5'b00010) || (s1.ty == 5'b00100);
      reads2 = (s2.ty == 5'b00001) || (s2.ty == 5'b00010) || (s2.ty == 5'b01000);
      if (!writes || s1.rd == 5'd0) return 1'b0;
      return (s1.rd == s2.rs1) || (reads2 && s1.rd == s2.rs2);
   endfunction

   // Small register range so RAW hazards are frequent
   function automatic logic [31:0] rand_instr();
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rc;
      logic [11:0] im;
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rc = 5'($urandom_range(0, 7));
      im = 12'($urandom);
      case ($urandom_range(0, 6))
         0: return {7'b0000000, rb, ra, 3'b000, rc, 7'b0110011};
         1: return {7'b0000001, rb, ra, 3'b000, rc, 7'b0110011};
         2: return {im, ra, 3'b010, rc, 7'b0000011};
         3: return {im[11:5], rb, ra, 3'b010, im[4:0], 7'b0100011};
         4: return 32'h00000013;
         5: return $urandom;
         default: return {7'b0100000, rb, ra, 3'($urandom_range(0, 7)), rc, 7'b0110011};
      endcase
   endfunction

   task automatic model_update(input bit v, input logic [31:0] a, input logic [31:0] b,
                               input bit s1r, input bit pr);
      bit can_push;
      bit has;
      mpair_t p;
      can_push = (q.size() < DEPTH);
      has      = (q.size() > 0);
      if (pr && has) begin
         void'(q.pop_front());
         released = 1'b0;
      end else if (s1r && has) begin
         released = 1'b1;
      end
      if (v && can_push) begin
         p.a  = ref_decode(a);
         p.b  = ref_decode(b);
         p.hz = ref_hz(p.a, p.b);
         q.push_back(p);
      end
   endtask

   task automatic compare_all();
      mpair_t h;
      bit     pv;
      pv = (q.size() != 0);
      h  = pv ? q[0] : '0;
      check("instr_ready", instr_ready, q.size() < DEPTH);
      check("occupancy", occupancy, q.size());
      check("pair_valid", pair_valid, pv);
      check("type1", {type_nop1, type_store1, type_load1, type_mul1, type_add1}, h.a.ty);
      check("type2", {type_nop2, type_store2, type_load2, type_mul2, type_add2}, h.b.ty);
      check("rs1_1", rs1_1, h.a.rs1);
      check("rs2_1", rs2_1, h.a.rs2);
      check("rd_1", rd_1, h.a.rd);
      check("rs1_2", rs1_2, h.b.rs1);
      check("rs2_2", rs2_2, h.b.rs2);
      check("rd_2", rd_2, h.b.rd);
      check("immediate1", immediate1, h.a.imm);
      check("immediate2", immediate2, h.b.imm);
      check("illegal1", illegal1, h.a.ill);
      check("illegal2", illegal2, h.b.ill);
      check("data_hazard", data_hazard, pv && h.hz && !released);
   endtask

   task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit s1r, input bit pr);
      @(negedge clk);
      instr_valid  = v;
      instr1       = a;
      instr2       = b;
      slot1_retire = s1r;
      pair_retire  = pr;
      @(posedge clk);
      model_update(v, a, b, s1r, pr);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      compare_all();
      check("reset_ready", instr_ready, 1'b1);

      // add x3,x1,x2 ; nop
      step(1'b1, 32'h002081B3, 32'h00000013, 1'b0, 1'b0);
      check("tp1_valid", pair_valid, 1'b1);
      check("tp1_add1", type_add1, 1'b1);
      check("tp1_rs1_1", rs1_1, 5'd1);
      check("tp1_rs2_1", rs2_1, 5'd2);
      check("tp1_rd_1", rd_1, 5'd3);
      check("tp1_nop2", type_nop2, 1'b1);
      check("tp1_hz", data_hazard, 1'b0);
      check("tp1_occ", occupancy, 3'd1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // add x3 ; mul x4,x3,x5 -> RAW, released by slot1_retire
      step(1'b1, 32'h002081B3, 32'h02518233, 1'b0, 1'b0);
      check("tp2_hz", data_hazard, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("tp2_hz_rel", data_hazard, 1'b0);
      check("tp2_valid_rel", pair_valid, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      check("tp2_empty", pair_valid, 1'b0);

      // lw x6,8(x1) ; sw x6,12(x2)
      step(1'b1, 32'h0080A303, 32'h00612623, 1'b0, 1'b0);
      check("tp3_imm1", immediate1, 32'd8);
      check("tp3_imm2", immediate2, 32'd12);
      check("tp3_rd2", rd_2, 5'd0);
      check("tp3_hz", data_hazard, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

      // lw x7,-4(x2) ; illegal
      step(1'b1, 32'hFFC12383, 32'hFFFFFFFF, 1'b0, 1'b0);
      check("tp4_imm1", immediate1, 32'hFFFFFFFC);
      check("tp4_nop2", type_nop2, 1'b1);
      check("tp4_ill2", illegal2, 1'b1);
      check("tp4_hz", data_hazard, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Fill, refuse a fifth pair, drain in order, then wrap the pointers
      for (int i = 0; i < DEPTH; i++) step(1'b1, rand_instr(), rand_instr(), 1'b0, 1'b0);
      check("full_ready", instr_ready, 1'b0);
      check("full_occ", occupancy, 3'd4);
      step(1'b1, rand_instr(), rand_instr(), 1'b0, 1'b0);
      check("full_reject_occ", occupancy, 3'd4);
      step(1'b1, rand_instr(), rand_instr(), 1'b0, 1'b1);
      check("full_pop_no_push", occupancy, 3'd3);
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, rand_instr(), rand_instr(), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 7), rand_instr(), rand_instr(),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4));
      end
      for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Three pairs with a hazard at the head, then asynchronous reset
      step(1'b1, 32'h002081B3, 32'h02518233, 1'b0, 1'b0);
      step(1'b1, 32'h0080A303, 32'h00612623, 1'b0, 1'b0);
      step(1'b1, 32'h00000013, 32'h00000013, 1'b0, 1'b0);
      check("pre_rst_occ", occupancy, 3'd3);
      check("pre_rst_hz", data_hazard, 1'b1);
      @(negedge clk);
      instr_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      q.delete();
      released = 1'b0;
      compare_all();
      check("async_rst_valid", pair_valid, 1'b0);
      check("async_rst_ready", instr_ready, 1'b1);
      check("async_rst_occ", occupancy, 3'd0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("retire_empty_occ", occupancy, 3'd0);
      check("retire_empty_valid", pair_valid, 1'b0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
